// File: rtl/axi_line_mem.sv
// Line-granular single-beat AXI slave memory with independent read/write engines
// and fixed response latency. Optional macro AXI_LINE_MEM_RAND_DELAY_EN adds 0..3 LFSR-driven wait cycles.
module axi_line_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 512,
  parameter int STRB_BITS  = 64,
  parameter int MEM_LINES  = 1024,
  parameter int RD_LATENCY = 3,
  parameter int WR_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [LINE_BITS-1:0]  axi_wdata,
  input  logic [STRB_BITS-1:0]  axi_wstrb,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [LINE_BITS-1:0]  axi_rdata,
  output logic [1:0]            axi_rresp
);

  localparam int OFF_W   = $clog2(STRB_BITS);
  localparam int IDX_W   = ADDR_WIDTH - OFF_W;
  localparam int MEM_AW  = $clog2(MEM_LINES);
  localparam int MAX_LAT = ((RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY) + 3;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_e;

  function automatic logic oor(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} >= (IDX_W+1)'(MEM_LINES);
  endfunction

  logic unused_ok;
  assign unused_ok = ^{axi_awaddr[OFF_W-1:0], axi_araddr[OFF_W-1:0]};

  // Single-stage release synchronizer: assertion is immediate, release lands on
  // the next edge so readies come up in the first cycle after reset.
  logic rst_sync_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= 1'b0;
    else      rst_sync_q <= 1'b1;
  end

  logic [CNT_W-1:0] rd_extra, wr_extra;
`ifdef AXI_LINE_MEM_RAND_DELAY_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) lfsr_q <= 16'hACE1;
    else             lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end
  assign rd_extra = CNT_W'(lfsr_q[1:0]);
  assign wr_extra = CNT_W'(lfsr_q[1:0]);
`else
  assign rd_extra = '0;
  assign wr_extra = '0;
`endif

  logic [LINE_BITS-1:0] mem [MEM_LINES];

  // ---------------- write engine ----------------
  wstate_e              wstate_q, wstate_d;
  logic                 aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [IDX_W-1:0]     widx_q;
  logic [LINE_BITS-1:0] wdata_q;
  logic [STRB_BITS-1:0] wstrb_q;
  logic                 wlast_q;
  logic                 aw_cap, w_cap, commit, wr_err;

  assign wr_err = oor(widx_q) || !wlast_q;

  always_comb begin
    wstate_d = wstate_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    wcnt_d   = wcnt_q;
    bresp_d  = bresp_q;
    aw_cap   = 1'b0;
    w_cap    = 1'b0;
    commit   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_got_q && w_got_q) begin
          commit   = !wr_err;
          bresp_d  = wr_err ? 2'b10 : 2'b00;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
          wcnt_d   = CNT_W'(WR_LATENCY - 1) + wr_extra;
          wstate_d = W_WAIT;
        end else begin
          aw_cap = axi_awvalid && !aw_got_q;
          w_cap  = axi_wvalid && !w_got_q;
          if (aw_cap) aw_got_d = 1'b1;
          if (w_cap)  w_got_d  = 1'b1;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) wstate_d = W_RESP;
        else              wcnt_d   = wcnt_q - CNT_W'(1);
      end
      W_RESP: if (axi_bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wstate_q <= W_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      wcnt_q   <= '0;
      bresp_q  <= 2'b00;
    end else begin
      wstate_q <= wstate_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_cap) widx_q <= axi_awaddr[ADDR_WIDTH-1:OFF_W];
    if (w_cap) begin
      wdata_q <= axi_wdata;
      wstrb_q <= axi_wstrb;
      wlast_q <= axi_wlast;
    end
  end

  assign axi_awready = rst_sync_q && (wstate_q == W_IDLE) && !aw_got_q;
  assign axi_wready  = rst_sync_q && (wstate_q == W_IDLE) && !w_got_q;
  assign axi_bvalid  = (wstate_q == W_RESP);
  assign axi_bresp   = bresp_q;

  // ---------------- read engine ----------------
  rstate_e              rstate_q, rstate_d;
  logic [CNT_W-1:0]     rcnt_q, rcnt_d;
  logic [IDX_W-1:0]     ridx_q, ridx_d;
  logic [1:0]           rresp_q, rresp_d;
  logic [LINE_BITS-1:0] mem_rd_q;
  logic                 rd_sample;

  always_comb begin
    rstate_d  = rstate_q;
    rcnt_d    = rcnt_q;
    ridx_d    = ridx_q;
    rresp_d   = rresp_q;
    rd_sample = 1'b0;
    case (rstate_q)
      R_IDLE: if (axi_arvalid) begin
        ridx_d   = axi_araddr[ADDR_WIDTH-1:OFF_W];
        rcnt_d   = CNT_W'(RD_LATENCY - 1) + rd_extra;
        rstate_d = R_WAIT;
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rd_sample = 1'b1;
          rresp_d   = oor(ridx_q) ? 2'b10 : 2'b00;
          rstate_d  = R_DATA;
        end else begin
          rcnt_d = rcnt_q - CNT_W'(1);
        end
      end
      R_DATA: if (axi_rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= '0;
      ridx_q   <= '0;
      rresp_q  <= 2'b00;
    end else begin
      rstate_q <= rstate_d;
      rcnt_q   <= rcnt_d;
      ridx_q   <= ridx_d;
      rresp_q  <= rresp_d;
    end
  end

  // Read and write share one process so a same-edge sample sees the old line.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < STRB_BITS; b++)
        if (wstrb_q[b]) mem[widx_q[MEM_AW-1:0]][b*8 +: 8] <= wdata_q[b*8 +: 8];
    end
    if (rd_sample) mem_rd_q <= mem[ridx_q[MEM_AW-1:0]];
  end

  assign axi_arready = rst_sync_q && (rstate_q == R_IDLE);
  assign axi_rvalid  = (rstate_q == R_DATA);
  assign axi_rresp   = rresp_q;
  assign axi_rdata   = (axi_rvalid && !rresp_q[1]) ? mem_rd_q : '0;

endmodule

// File: tb/tb_axi_line_mem.sv
// Scoreboard bench for axi_line_mem: driver pushes expected responses, monitors pop on handshakes.
module tb_axi_line_mem;
  localparam int RDL = 3;
  localparam int WRL = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         axi_awvalid, axi_awready;
  logic [31:0]  axi_awaddr;
  logic         axi_wvalid, axi_wready;
  logic [511:0] axi_wdata;
  logic [63:0]  axi_wstrb;
  logic         axi_wlast;
  logic         axi_bvalid, axi_bready;
  logic [1:0]   axi_bresp;
  logic         axi_arvalid, axi_arready;
  logic [31:0]  axi_araddr;
  logic         axi_rvalid, axi_rready;
  logic [511:0] axi_rdata;
  logic [1:0]   axi_rresp;

  axi_line_mem dut (
    .clk(clk), .rst(rst),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [1:0]   resp;
  } rexp_t;

  rexp_t      rq[$];
  logic [1:0] bq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [511:0] fill(input logic [7:0] b);
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[k*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [511:0] pat();
    logic [511:0] v;
    for (int k = 0; k < 64; k++) v[k*8 +: 8] = 8'(k);
    return v;
  endfunction

  task automatic chk(input string name, input logic ok, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Read-response monitor
  always @(negedge clk) begin
    #1;
    if (axi_rvalid && axi_rready) begin
      checks++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got resp %b", axi_rresp);
      end else begin
        rexp_t e;
        e = rq.pop_front();
        if (axi_rdata !== e.data || axi_rresp !== e.resp) begin
          errors++;
          $display("FAIL rd_resp got %h/%b want %h/%b", axi_rdata, axi_rresp, e.data, e.resp);
        end
      end
    end
  end

  // Write-response monitor
  always @(negedge clk) begin
    #1;
    if (axi_bvalid && axi_bready) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got bresp %b", axi_bresp);
      end else begin
        logic [1:0] e;
        e = bq.pop_front();
        if (axi_bresp !== e) begin
          errors++;
          $display("FAIL wr_bresp got %b want %b", axi_bresp, e);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [511:0] data, input logic [63:0] strb,
                    input logic last, input int lead, input int hold, input logic [1:0] exp);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    aw_done = 0; w_done = 0;
    bq.push_back(exp);
    axi_bready = (hold == 0);
    @(negedge clk);
    axi_awaddr = addr; axi_wdata = data; axi_wstrb = strb; axi_wlast = last;
    for (int t = 0; t < 50 && !(aw_done && w_done); t++) begin
      axi_awvalid = !aw_done && (t >= lead);
      axi_wvalid  = !w_done;
      aw_hs = axi_awvalid && axi_awready;
      w_hs  = axi_wvalid && axi_wready;
      @(negedge clk);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
    end
    axi_awvalid = 0; axi_wvalid = 0;
    chk("wr_accept", aw_done && w_done, 512'(aw_done), 512'(1));
    n = 0;
    while (!axi_bvalid && n < 30) begin @(negedge clk); n++; end
    chk("wr_latency", n == WRL + 1, 512'(n), 512'(WRL + 1));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("wr_hold", axi_bvalid && axi_bresp == exp && !axi_awready && !axi_wready,
          512'({axi_bvalid, axi_bresp, axi_awready, axi_wready}), 512'({1'b1, exp, 2'b00}));
    end
    axi_bready = 1;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] addr, input int hold, input logic [511:0] exp, input logic [1:0] er);
    bit hs, done;
    int n;
    rexp_t e;
    e.data = exp; e.resp = er;
    rq.push_back(e);
    axi_rready = (hold == 0);
    done = 0;
    @(negedge clk);
    axi_araddr = addr;
    for (int t = 0; t < 50 && !done; t++) begin
      axi_arvalid = 1;
      hs = axi_arready;
      @(negedge clk);
      if (hs) done = 1;
    end
    axi_arvalid = 0;
    chk("rd_accept", done, 512'(done), 512'(1));
    n = 0;
    while (!axi_rvalid && n < 30) begin @(negedge clk); n++; end
    chk("rd_latency", n == RDL, 512'(n), 512'(RDL));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rd_hold", axi_rvalid && axi_rdata == exp && axi_rresp == er && !axi_arready,
          axi_rdata, exp);
    end
    axi_rready = 1;
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rq.size() != 0 || bq.size() != 0); i++) @(negedge clk);
    chk("drain", rq.size() == 0 && bq.size() == 0, 512'(rq.size() + bq.size()), 512'(0));
  endtask

  logic [511:0] pv, pp;

  initial begin
    rst = 0;
    axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
    axi_awaddr = 0; axi_araddr = 0; axi_wdata = '0; axi_wstrb = '0; axi_wlast = 1;
    axi_bready = 1; axi_rready = 1;

    // 1. reset
    repeat (3) @(negedge clk);
    chk("rst_outputs", {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} == 5'b0,
        512'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid}), 512'(0));
    chk("rst_resp", axi_bresp == 2'b00 && axi_rresp == 2'b00 && axi_rdata == '0,
        512'({axi_bresp, axi_rresp}), 512'(0));
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
    rst = 1;
    #1;
    chk("ready_pre_edge", {axi_awready, axi_wready, axi_arready} == 3'b000,
        512'({axi_awready, axi_wready, axi_arready}), 512'(0));
    @(negedge clk);
    chk("ready_after_release", {axi_awready, axi_wready, axi_arready} == 3'b111,
        512'({axi_awready, axi_wready, axi_arready}), 512'(7));

    // known background lines
    wr(32'h0000_2000, fill(8'h00), '1, 1, 0, 0, 2'b00);
    wr(32'h0000_0000, fill(8'h11), '1, 1, 0, 0, 2'b00);
    wr(32'h0000_0040, fill(8'h22), '1, 1, 0, 0, 2'b00);

    // 2. full-line write then read; offset bits ignored
    pv = pat();
    wr(32'h0000_1000, pv, '1, 1, 0, 0, 2'b00);
    rd(32'h0000_1000, 0, pv, 2'b00);
    rd(32'h0000_103F, 0, pv, 2'b00);

    // 3. partial strobe, same-cycle and W-first ordering
    pp = pv;
    pp[63:32] = 32'hFFFF_FFFF;
    wr(32'h0000_1000, fill(8'hFF), 64'h0000_0000_0000_00F0, 1, 0, 0, 2'b00);
    rd(32'h0000_1000, 0, pp, 2'b00);
    wr(32'h0000_1000, pv, '1, 1, 0, 0, 2'b00);
    wr(32'h0000_1000, fill(8'hFF), 64'h0000_0000_0000_00F0, 1, 2, 0, 2'b00);
    rd(32'h0000_1000, 0, pp, 2'b00);

    // 4. back-pressure
    rd(32'h0000_1000, 5, pp, 2'b00);
    wr(32'h0000_0040, fill(8'h22), '1, 1, 0, 5, 2'b00);

    // 5. errors
    wr(32'h0001_0000, fill(8'h5A), '1, 1, 0, 0, 2'b10);
    rd(32'h0000_0000, 0, fill(8'h11), 2'b00);
    rd(32'h0001_0000, 0, '0, 2'b10);
    wr(32'h0000_0040, fill(8'h77), '1, 0, 0, 0, 2'b10);
    rd(32'h0000_0040, 0, fill(8'h22), 2'b00);

    // 6. read sample and write commit on the same edge
    begin
      rexp_t e;
      e.data = fill(8'h00); e.resp = 2'b00;
      rq.push_back(e);
      bq.push_back(2'b00);
      axi_rready = 1; axi_bready = 1;
      @(negedge clk);
      chk("coll_idle", axi_arready && axi_awready && axi_wready,
          512'({axi_arready, axi_awready, axi_wready}), 512'(7));
      axi_araddr = 32'h0000_2000; axi_arvalid = 1;
      @(negedge clk);
      axi_arvalid = 0;
      @(negedge clk);
      axi_awaddr = 32'h0000_2000; axi_wdata = fill(8'hAA); axi_wstrb = '1; axi_wlast = 1;
      axi_awvalid = 1; axi_wvalid = 1;
      @(negedge clk);
      axi_awvalid = 0; axi_wvalid = 0;
      drain();
    end
    rd(32'h0000_2000, 0, fill(8'hAA), 2'b00);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
